riscv_wb_arbiter: RTL and testbench
===================================

# riscv_wb_arbiter

Writeback arbiter and register scoreboard for the RISC-V core. Shares the single register-file write port between three producers (ALU, load unit, mul/div) with round-robin arbitration, and tracks in-flight destination registers so that issue stalls on RAW/WAW hazards. Sits between the execution units and `riscv_register_file`; its `wb_*` outputs drive `rd_addr`/`rd_data`/`rd_we` directly.

## Interface
- No parameters; requester count fixed at 3 (index 0 = ALU, 1 = load, 2 = mul/div).
- `clk` in 1: clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 3: per-requester writeback request.
- `req_addr` in 15: destination, requester i at bits [5i+4:5i].
- `req_data` in 96: result, requester i at bits [32i+31:32i].
- `req_ready` out 3: one-hot grant; transfer when valid & ready at the edge.
- `wb_addr` out 5 / `wb_data` out 32 / `wb_we` out 1: registered write to the register file.
- `issue_valid` in 1: decode presents an instruction.
- `issue_rs1`, `issue_rs2`, `issue_rd` in 5 each: its operands and destination.
- `issue_stall` out 1: combinational; instruction must not issue this cycle.
- `pending_mask` out 32: scoreboard contents (bit 0 always 0).
- `fwd_rs1_valid`, `fwd_rs2_valid` out 1 / `fwd_rs1_data`, `fwd_rs2_data` out 32: bypass (only with RISCV_WB_BYPASS_EN).

## Operation
- Arbitration: round-robin pointer `ptr` (0..2); highest priority is `ptr`, then `ptr+1`, `ptr+2` mod 3. `req_ready` = grant, combinational, at most one bit set, zero when no `req_valid`. Grant to i → `ptr` = (i+1) mod 3. No grant → `ptr` unchanged.
- Output stage: accepted request loads `wb_addr`/`wb_data`; `wb_we` = 1 for that cycle only, if addr ≠ 0. Accepted x0 write: consumed, `wb_we` = 0, scoreboard untouched. No acceptance → `wb_we` = 0, addr/data hold.
- Scoreboard `pending[31:0]`: set bit `issue_rd` at edge when `issue_valid & ~issue_stall & issue_rd ≠ 0`. Clear point per Configuration.
- `issue_stall` = `issue_valid` & (pending[rs1] | pending[rs2] | pending[rd]), each term ignored when its index is 0. WAW term guarantees one outstanding write per register.
- Same-edge set and clear of one bit: set wins.
- Requester writing a register with no pending bit is legal; write performed, scoreboard unchanged.

## Timing
- Reset (async, immediate): `wb_addr`=0, `wb_data`=0, `wb_we`=0, `ptr`=0, `pending`=0, fwd outputs 0; `req_ready`/`issue_stall` follow inputs combinationally (grant to lowest valid index).
- Latency: accepted at edge N → `wb_we` high during cycle N+1 → register file updated at edge N+1 → readable in cycle N+2.
- Throughput: one writeback per cycle; back-to-back grants permitted.
- Reset asserted mid-operation: in-flight `wb_we` dropped, scoreboard emptied; producers must be reset alongside.

## Configuration
- Macro `RISCV_WB_BYPASS_EN`.
- Defined: pending bit clears at acceptance edge N; during N+1 `fwd_rsK_valid` = `wb_we` & `wb_addr` == `issue_rsK` & `issue_rsK` ≠ 0, `fwd_rsK_data` = `wb_data`; dependent instruction issues in N+1.
- Undefined: pending bit clears at edge N+1 (when `wb_we` is high); dependent issues in N+2; fwd outputs tied to 0.

## Test plan
- Reset then `req_valid`=3'b111 held 4 cycles → grants 0,1,2,0; `wb_we` high cycles 2-5 with each requester's addr/data.
- Issue rd=5; next cycle issue rs1=5 → `issue_stall`=1; ALU writes x5=0xDEADBEEF → stall drops cycle N+1 (bypass, fwd_rs1_data=0xDEADBEEF) or N+2 (no bypass).
- Request addr 0 data 0x1234 → `req_ready` asserted, `wb_we` stays 0, `pending_mask` unchanged.
- x7 pending, issue rd=7 while load writes x7 same edge → WAW stall holds until clear; then set for new producer; never both set and cleared lost (set wins case: final pending[7]=1).
- Issue rs1=rs2=rd=0 with pending_mask=0xFFFFFFFE → `issue_stall`=0.
- `rst_n` low mid-cycle with `wb_we`=1, pending[3]=1 → `wb_we`=0, `pending_mask`=0 immediately, `ptr`=0.

Source files
------------

// File: rtl/riscv_wb_arbiter_if.sv
// Bundle of writeback request, register-file write, issue/scoreboard and forwarding
// signals shared between the execution units, decode and riscv_wb_arbiter.
interface riscv_wb_arbiter_if;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;

  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_we;

  logic        issue_valid;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic [4:0]  issue_rd;
  logic        issue_stall;
  logic [31:0] pending_mask;

  logic        fwd_rs1_valid;
  logic        fwd_rs2_valid;
  logic [31:0] fwd_rs1_data;
  logic [31:0] fwd_rs2_data;

  // Producers and decode drive requests/issue; the arbiter answers.
  modport master (
    output req_valid, req_addr, req_data,
    output issue_valid, issue_rs1, issue_rs2, issue_rd,
    input  req_ready, wb_addr, wb_data, wb_we,
    input  issue_stall, pending_mask,
    input  fwd_rs1_valid, fwd_rs2_valid, fwd_rs1_data, fwd_rs2_data
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    input  issue_valid, issue_rs1, issue_rs2, issue_rd,
    output req_ready, wb_addr, wb_data, wb_we,
    output issue_stall, pending_mask,
    output fwd_rs1_valid, fwd_rs2_valid, fwd_rs1_data, fwd_rs2_data
  );
endinterface

// File: rtl/riscv_wb_arbiter.sv
// Round-robin writeback arbiter (ALU, load, mul/div) with a register scoreboard that
// stalls issue on RAW/WAW hazards. Optional forwarding path: define RISCV_WB_BYPASS_EN.
module riscv_wb_arbiter (
  input  logic              clk,
  input  logic              rst_n,
  riscv_wb_arbiter_if.slave bus
);
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic [1:0]        ptr;
  logic [2:0]        grant_p0;
  logic              acc_p0;
  logic [ADDR_W-1:0] sel_addr_p0;
  logic [DATA_W-1:0] sel_data_p0;

  logic              vld_p1;
  logic [ADDR_W-1:0] wb_addr_p1;
  logic [DATA_W-1:0] wb_data_p1;

  logic [31:0]       pending;
  logic [31:0]       set_vec;
  logic [31:0]       clr_vec;
  logic              stall;

  function automatic logic [2:0] rr_grant(input logic [2:0] v, input logic [1:0] p);
    logic [2:0] g;
    g = 3'b000;
    case (p)
      2'd1: begin
        if (v[1])      g = 3'b010;
        else if (v[2]) g = 3'b100;
        else if (v[0]) g = 3'b001;
      end
      2'd2: begin
        if (v[2])      g = 3'b100;
        else if (v[0]) g = 3'b001;
        else if (v[1]) g = 3'b010;
      end
      default: begin
        if (v[0])      g = 3'b001;
        else if (v[1]) g = 3'b010;
        else if (v[2]) g = 3'b100;
      end
    endcase
    return g;
  endfunction

  // Pointer moves to the requester just after the one granted.
  function automatic logic [1:0] next_ptr(input logic [2:0] g);
    logic [1:0] n;
    n = 2'd0;
    if (g[0])      n = 2'd1;
    else if (g[1]) n = 2'd2;
    return n;
  endfunction

  function automatic logic [31:0] onehot32(input logic [ADDR_W-1:0] a);
    return 32'd1 << a;
  endfunction

  function automatic logic busy(input logic [31:0] p, input logic [ADDR_W-1:0] r);
    return (r != '0) && p[r];
  endfunction

  // ---- p0: arbitration and request select ----
  always_comb begin
    grant_p0 = rr_grant(bus.req_valid, ptr);
    acc_p0   = |grant_p0;
  end

  always_comb begin
    sel_addr_p0 = '0;
    sel_data_p0 = '0;
    for (int i = 0; i < 3; i++) begin
      if (grant_p0[i]) begin
        sel_addr_p0 = bus.req_addr[ADDR_W*i +: ADDR_W];
        sel_data_p0 = bus.req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr <= 2'd0;
    else if (acc_p0) ptr <= next_ptr(grant_p0);
  end

  // ---- p1: registered register-file write ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      wb_addr_p1 <= '0;
      wb_data_p1 <= '0;
    end else if (acc_p0) begin
      vld_p1     <= (sel_addr_p0 != '0);
      wb_addr_p1 <= sel_addr_p0;
      wb_data_p1 <= sel_data_p0;
    end else begin
      vld_p1     <= 1'b0;
    end
  end

  // ---- scoreboard ----
  always_comb begin
    stall = bus.issue_valid &
            (busy(pending, bus.issue_rs1) |
             busy(pending, bus.issue_rs2) |
             busy(pending, bus.issue_rd));
    set_vec = '0;
    if (bus.issue_valid && !stall && bus.issue_rd != '0)
      set_vec = onehot32(bus.issue_rd);
    clr_vec = '0;
`ifdef RISCV_WB_BYPASS_EN
    if (acc_p0 && sel_addr_p0 != '0)
      clr_vec = onehot32(sel_addr_p0);
`else
    if (vld_p1)
      clr_vec = onehot32(wb_addr_p1);
`endif
  end

  // Set is OR-ed in after the clear so a same-edge set of one bit wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= ((pending & ~clr_vec) | set_vec) & 32'hFFFF_FFFE;
  end

  assign bus.req_ready    = grant_p0;
  assign bus.wb_addr      = wb_addr_p1;
  assign bus.wb_data      = wb_data_p1;
  assign bus.wb_we        = vld_p1;
  assign bus.issue_stall  = stall;
  assign bus.pending_mask = pending;

`ifdef RISCV_WB_BYPASS_EN
  // The write in flight this cycle already left the scoreboard; forward its data.
  assign bus.fwd_rs1_valid = vld_p1 && (wb_addr_p1 == bus.issue_rs1) && (bus.issue_rs1 != '0);
  assign bus.fwd_rs2_valid = vld_p1 && (wb_addr_p1 == bus.issue_rs2) && (bus.issue_rs2 != '0);
  assign bus.fwd_rs1_data  = wb_data_p1;
  assign bus.fwd_rs2_data  = wb_data_p1;
`else
  assign bus.fwd_rs1_valid = 1'b0;
  assign bus.fwd_rs2_valid = 1'b0;
  assign bus.fwd_rs1_data  = '0;
  assign bus.fwd_rs2_data  = '0;
`endif
endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Bench for riscv_wb_arbiter: directed vectors with literal expectations plus a
// per-cycle comparison against a behavioural arbiter/scoreboard model.
module tb_riscv_wb_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  riscv_wb_arbiter_if bus();
  riscv_wb_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  int        m_ptr     = 0;
  bit [31:0] m_pend    = '0;
  bit [4:0]  m_wb_addr = '0;
  bit [31:0] m_wb_data = '0;
  bit        m_wb_we   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_grant_idx();
    for (int k = 0; k < 3; k++) begin
      int i = (m_ptr + k) % 3;
      if (bus.req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit m_busy(input logic [4:0] r);
    return (r != 5'd0) && m_pend[r];
  endfunction

  function automatic bit m_stall();
    return bus.issue_valid &&
           (m_busy(bus.issue_rs1) || m_busy(bus.issue_rs2) || m_busy(bus.issue_rd));
  endfunction

  // Behavioural model: state advances on each clock edge, clears immediately on reset.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_ptr = 0; m_pend = '0; m_wb_addr = '0; m_wb_data = '0; m_wb_we = 1'b0;
    end else begin
      int g;
      bit [31:0] nxt;
      bit [4:0]  ga;
      g   = m_grant_idx();
      nxt = m_pend;
      ga  = (g >= 0) ? bus.req_addr[5*g +: 5] : 5'd0;
`ifdef RISCV_WB_BYPASS_EN
      if (g >= 0 && ga != 5'd0) nxt[ga] = 1'b0;
`else
      if (m_wb_we) nxt[m_wb_addr] = 1'b0;
`endif
      if (bus.issue_valid && !m_stall() && bus.issue_rd != 5'd0) nxt[bus.issue_rd] = 1'b1;
      m_pend = nxt;
      if (g >= 0) begin
        m_wb_addr = ga;
        m_wb_data = bus.req_data[32*g +: 32];
        m_wb_we   = (ga != 5'd0);
        m_ptr     = (g + 1) % 3;
      end else begin
        m_wb_we = 1'b0;
      end
    end
  end

  // Compare every output against the model mid-cycle.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      int g;
      logic [2:0] eg;
      bit e1v, e2v;
      g  = m_grant_idx();
      eg = 3'b000;
      if (g >= 0) eg[g] = 1'b1;
`ifdef RISCV_WB_BYPASS_EN
      e1v = m_wb_we && m_wb_addr == bus.issue_rs1 && bus.issue_rs1 != 5'd0;
      e2v = m_wb_we && m_wb_addr == bus.issue_rs2 && bus.issue_rs2 != 5'd0;
      chk("m_fwd1_data", bus.fwd_rs1_data, m_wb_data);
      chk("m_fwd2_data", bus.fwd_rs2_data, m_wb_data);
`else
      e1v = 1'b0;
      e2v = 1'b0;
      chk("m_fwd1_data", bus.fwd_rs1_data, 32'd0);
      chk("m_fwd2_data", bus.fwd_rs2_data, 32'd0);
`endif
      chk("m_req_ready", 32'(bus.req_ready), 32'(eg));
      chk("m_wb_we",     32'(bus.wb_we), 32'(m_wb_we));
      chk("m_wb_addr",   32'(bus.wb_addr), 32'(m_wb_addr));
      chk("m_wb_data",   bus.wb_data, m_wb_data);
      chk("m_pending",   bus.pending_mask, m_pend);
      chk("m_stall",     32'(bus.issue_stall), 32'(m_stall()));
      chk("m_fwd1_vld",  32'(bus.fwd_rs1_valid), 32'(e1v));
      chk("m_fwd2_vld",  32'(bus.fwd_rs2_valid), 32'(e2v));
    end
  end

  task automatic idle();
    bus.req_valid = 3'b000; bus.req_addr = '0; bus.req_data = '0;
    bus.issue_valid = 1'b0; bus.issue_rs1 = '0; bus.issue_rs2 = '0; bus.issue_rd = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    bus.issue_valid = 1'b1; bus.issue_rs1 = rs1; bus.issue_rs2 = rs2; bus.issue_rd = rd;
  endtask

  initial begin
    logic [2:0] exp_g [4];
    logic [4:0] exp_a [4];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_a = '{5'd1, 5'd2, 5'd3, 5'd1};
    idle();
    bus.req_valid = 3'b110;
    tick();
    chk_en = 1'b1;
    #1;
    chk("rst_wb_we",     32'(bus.wb_we), 32'd0);
    chk("rst_wb_addr",   32'(bus.wb_addr), 32'd0);
    chk("rst_wb_data",   bus.wb_data, 32'd0);
    chk("rst_pending",   bus.pending_mask, 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'b010);
    idle();
    tick();
    rst_n = 1'b1;

    // All three requesters continuously: 0,1,2,0.
    bus.req_valid = 3'b111;
    bus.req_addr  = {5'd3, 5'd2, 5'd1};
    bus.req_data  = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    #1 chk("rr_grant0", 32'(bus.req_ready), 32'(exp_g[0]));
    for (int c = 1; c < 4; c++) begin
      tick();
      chk("rr_grant", 32'(bus.req_ready), 32'(exp_g[c]));
      chk("rr_wb_we", 32'(bus.wb_we), 32'd1);
      chk("rr_wb_addr", 32'(bus.wb_addr), 32'(exp_a[c-1]));
    end
    tick();
    idle();
    #1;
    chk("rr_last_addr", 32'(bus.wb_addr), 32'd1);
    chk("rr_last_data", bus.wb_data, 32'hAAAA0000);
    tick();
    chk("hold_we",   32'(bus.wb_we), 32'd0);
    chk("hold_addr", 32'(bus.wb_addr), 32'd1);

    // RAW on x5 resolved by an ALU write.
    issue(5'd0, 5'd0, 5'd5);
    #1 chk("raw_first_issue", 32'(bus.issue_stall), 32'd0);
    tick();
    issue(5'd5, 5'd0, 5'd0);
    #1;
    chk("raw_pending", bus.pending_mask, 32'h20);
    chk("raw_stall",   32'(bus.issue_stall), 32'd1);
    tick();
    bus.req_valid = 3'b001;
    bus.req_addr  = {10'd0, 5'd5};
    bus.req_data  = {64'd0, 32'hDEADBEEF};
    #1 chk("raw_grant", 32'(bus.req_ready), 32'b001);
    tick();
    bus.req_valid = 3'b000;
    #1;
`ifdef RISCV_WB_BYPASS_EN
    chk("raw_n1_stall",  32'(bus.issue_stall), 32'd0);
    chk("raw_fwd_vld",   32'(bus.fwd_rs1_valid), 32'd1);
    chk("raw_fwd_data",  bus.fwd_rs1_data, 32'hDEADBEEF);
`else
    chk("raw_n1_stall",  32'(bus.issue_stall), 32'd1);
    chk("raw_n1_we",     32'(bus.wb_we), 32'd1);
    tick();
    chk("raw_n2_stall",  32'(bus.issue_stall), 32'd0);
`endif
    chk("raw_cleared", bus.pending_mask, 32'd0);
    tick();
    idle();

    // Write to x0 is consumed without touching the register file.
    bus.req_valid = 3'b010;
    bus.req_data  = {32'd0, 32'h00001234, 32'd0};
    #1 chk("x0_grant", 32'(bus.req_ready), 32'b010);
    tick();
    idle();
    #1;
    chk("x0_we",      32'(bus.wb_we), 32'd0);
    chk("x0_data",    bus.wb_data, 32'h00001234);
    chk("x0_pending", bus.pending_mask, 32'd0);

    // WAW on x7 while the load writes x7.
    issue(5'd0, 5'd0, 5'd7);
    tick();
    issue(5'd0, 5'd0, 5'd7);
    bus.req_valid = 3'b010;
    bus.req_addr  = {5'd0, 5'd7, 5'd0};
    bus.req_data  = {32'd0, 32'h77, 32'd0};
    #1 chk("waw_stall", 32'(bus.issue_stall), 32'd1);
    tick();
    bus.req_valid = 3'b000;
    #1;
`ifdef RISCV_WB_BYPASS_EN
    chk("waw_n1_stall", 32'(bus.issue_stall), 32'd0);
`else
    chk("waw_n1_stall", 32'(bus.issue_stall), 32'd1);
    tick();
    chk("waw_n2_stall", 32'(bus.issue_stall), 32'd0);
`endif
    tick();
    idle();
    #1 chk("waw_reset_bit", bus.pending_mask, 32'h80);

    // Same-edge clear and set of x9: set wins.
    bus.req_valid = 3'b001;
    bus.req_addr  = {10'd0, 5'd9};
    bus.req_data  = {64'd0, 32'h9};
`ifndef RISCV_WB_BYPASS_EN
    tick();
    bus.req_valid = 3'b000;
    #1 chk("sw_we", 32'(bus.wb_we), 32'd1);
`endif
    issue(5'd0, 5'd0, 5'd9);
    #1 chk("sw_stall", 32'(bus.issue_stall), 32'd0);
    tick();
    idle();
    #1 chk("sw_pending", bus.pending_mask, 32'h280);

    // Fill the scoreboard, then x0-only instruction must not stall.
    for (int k = 1; k < 32; k++) begin
      issue(5'd0, 5'd0, 5'(k));
      tick();
    end
    idle();
    #1 chk("full_pending", bus.pending_mask, 32'hFFFFFFFE);
    issue(5'd0, 5'd0, 5'd0);
    #1 chk("full_x0_stall", 32'(bus.issue_stall), 32'd0);
    issue(5'd3, 5'd0, 5'd0);
    #1 chk("full_rs1_stall", 32'(bus.issue_stall), 32'd1);
    idle();

    // Asynchronous reset in the middle of a write cycle.
    bus.req_valid = 3'b100;
    bus.req_addr  = {5'd12, 10'd0};
    bus.req_data  = {32'h0000000C, 64'd0};
    tick();
    idle();
    #1 chk("pre_rst_we", 32'(bus.wb_we), 32'd1);
    bus.req_valid = 3'b110;
    bus.req_addr  = {5'd6, 5'd4, 5'd0};
    bus.req_data  = {32'h66, 32'h44, 32'h0};
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_we",      32'(bus.wb_we), 32'd0);
    chk("mid_rst_pending", bus.pending_mask, 32'd0);
    chk("mid_rst_addr",    32'(bus.wb_addr), 32'd0);
    chk("mid_rst_grant",   32'(bus.req_ready), 32'b010);
    tick();
    rst_n = 1'b1;
    #1 chk("post_rst_grant", 32'(bus.req_ready), 32'b010);
    tick();
    chk("post_rst_grant2", 32'(bus.req_ready), 32'b100);
    chk("post_rst_addr",   32'(bus.wb_addr), 32'd4);
    idle();
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
